// File: rtl/seg_scan_sched.sv
// Digit scan and page scheduler for the 4-digit level display: free-running scan, value page hold, level-change blink.
// scan/frame_tick are registered, din is combinational from registers; inputs are sampled every cycle with no backpressure.
module seg_scan_sched #(
  parameter int DIV         = 50000,
  parameter int HOLD_FRAMES = 200,
  parameter int BLINK_HALF  = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  lvl_i,
  input  logic [15:0] val_bcd_i,
  input  logic        show_req_i,
  output logic [1:0]  scan_o,
  output logic [3:0]  din_o,
  output logic        page_o,
  output logic        blank_o,
  output logic        frame_tick_o,
  output logic        busy_o
);

  localparam int BLINK_FRAMES = 4 * BLINK_HALF;
  localparam int MAX_CNT      = (HOLD_FRAMES > BLINK_FRAMES) ? HOLD_FRAMES : BLINK_FRAMES;
  localparam int CW           = $clog2(MAX_CNT + 1);
  localparam int PW           = $clog2(DIV);

  typedef enum logic [1:0] {ST_LEVEL, ST_SHOW, ST_BLINK} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [PW-1:0]   presc_q;
  logic [1:0]      scan_q;
  logic            frame_tick_q;
  logic [3:0]      lvl_q;
  logic [15:0]     val_q;

  logic            slot_tick;
  logic            lvl_evt;
  logic [CW-1:0]   cnt_inc;
  logic [CW-1:0]   blink_phase;

  assign slot_tick   = (presc_q == PW'(DIV - 1));
  assign lvl_evt     = (lvl_i != lvl_q);
  assign cnt_inc     = cnt_q + CW'(1);
  assign blink_phase = cnt_q / CW'(BLINK_HALF);

  // Scan timing free-runs; FSM events never disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      scan_q       <= '0;
      frame_tick_q <= 1'b0;
      lvl_q        <= '0;
      val_q        <= '0;
    end else begin
      presc_q      <= slot_tick ? '0 : presc_q + PW'(1);
      scan_q       <= slot_tick ? scan_q + 2'd1 : scan_q;
      frame_tick_q <= slot_tick && (scan_q == 2'd3);
      lvl_q        <= lvl_i;
      val_q        <= show_req_i ? val_bcd_i : val_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LEVEL;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    if (show_req_i) begin
      // A level change arriving with the request is remembered for after the hold.
      state_d = ST_SHOW;
      cnt_d   = '0;
      if (lvl_evt) pend_d = 1'b1;
    end else begin
      case (state_q)
        ST_LEVEL: begin
          if (lvl_evt) begin
            state_d = ST_BLINK;
            cnt_d   = '0;
          end
        end
        ST_SHOW: begin
          if (lvl_evt) pend_d = 1'b1;
          if (frame_tick_q) begin
            if (cnt_inc == CW'(HOLD_FRAMES)) begin
              state_d = (pend_q || lvl_evt) ? ST_BLINK : ST_LEVEL;
              cnt_d   = '0;
              pend_d  = 1'b0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        ST_BLINK: begin
          if (lvl_evt) begin
            cnt_d = '0;
          end else if (frame_tick_q) begin
            if (cnt_inc == CW'(BLINK_FRAMES)) begin
              state_d = ST_LEVEL;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: begin
          state_d = ST_LEVEL;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      endcase
    end
  end

  assign scan_o       = scan_q;
  assign page_o       = (state_q == ST_SHOW);
  assign busy_o       = (state_q != ST_LEVEL);
  assign blank_o      = (state_q == ST_BLINK) && blink_phase[0];
  assign frame_tick_o = frame_tick_q;
  assign din_o        = page_o ? val_q[{scan_q, 2'b00} +: 4] : lvl_q;

endmodule

// File: tb/tb_seg_scan_sched.sv
// Bench for seg_scan_sched: per-frame scoreboard of page/blank/busy and the four scanned digits.
module tb_seg_scan_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  lvl;
  logic [15:0] val_bcd;
  logic        show_req;
  logic [1:0]  scan;
  logic [3:0]  din;
  logic        page;
  logic        blank;
  logic        frame_tick;
  logic        busy;

  seg_scan_sched #(.DIV(4), .HOLD_FRAMES(3), .BLINK_HALF(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lvl_i        (lvl),
    .val_bcd_i    (val_bcd),
    .show_req_i   (show_req),
    .scan_o       (scan),
    .din_o        (din),
    .page_o       (page),
    .blank_o      (blank),
    .frame_tick_o (frame_tick),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        page;
    logic        blank;
    logic        busy;
    logic [15:0] din;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          frame_no = 0;
  logic [15:0] din_rec;
  logic        overlap;
  logic [7:0]  blink_pat;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic push(input logic p, input logic b, input logic y, input logic [15:0] d);
    exp_t e;
    e.page  = p;
    e.blank = b;
    e.busy  = y;
    e.din   = d;
    exp_q.push_back(e);
  endtask

  task automatic push_blink(input logic [15:0] d);
    for (int i = 0; i < 8; i++) push(1'b0, blink_pat[i], 1'b1, d);
  endtask

  // Wait for n frame_tick cycles (sampled on negedge), then step 2 time units past it.
  task automatic wait_ft(input int n);
    for (int i = 0; i < n; i++) begin
      int c;
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!frame_tick && c < 40);
      if (!frame_tick) begin
        checks++;
        failures++;
        $display("FAIL frame_tick_timeout: got none in %0d cycles, expected one", c);
      end
    end
    #2;
  endtask

  task automatic pulse_show(input logic [15:0] v);
    val_bcd  = v;
    show_req = 1'b1;
    @(posedge clk);
    #1 show_req = 1'b0;
  endtask

  // Monitor: at each frame_tick, compare the frame just completed with the next expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      din_rec = '0;
      overlap = 1'b0;
    end else begin
      if (page && blank) overlap = 1'b1;
      if (frame_tick) begin
        frame_no++;
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          checks++;
          if (page !== e.page || blank !== e.blank || busy !== e.busy || din_rec !== e.din) begin
            failures++;
            $display("FAIL frame%0d: got page=%0d blank=%0d busy=%0d digits=%h expected page=%0d blank=%0d busy=%0d digits=%h",
                     frame_no, page, blank, busy, din_rec, e.page, e.blank, e.busy, e.din);
          end
          checks++;
          if (overlap !== 1'b0) begin
            failures++;
            $display("FAIL frame%0d blank_on_value_page: got 1 expected 0", frame_no);
          end
        end
        overlap = 1'b0;
      end
      din_rec[{scan, 2'b00} +: 4] = din;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    blink_pat = 8'b1100_1100;
    rst_n    = 1'b0;
    lvl      = 4'd0;
    val_bcd  = 16'h0;
    show_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {24'd0, scan, din, page, blank, frame_tick, busy}, 32'd0);

    push(1'b0, 1'b0, 1'b0, 16'h0000);
    push(1'b0, 1'b0, 1'b0, 16'h0000);
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      logic [1:0] es;
      logic       ef;
      @(negedge clk);
      es = 2'((k / 4) % 4);
      ef = (k % 16 == 0);
      chk($sformatf("scan_cycle%0d", k), {24'd0, scan, ef ? 1'b1 : 1'b0, din, page},
          {24'd0, es, ef, 4'd0, 1'b0});
      chk($sformatf("frame_tick_cycle%0d", k), {31'd0, frame_tick}, {31'd0, ef});
    end
    #2;

    lvl = 4'd5;
    push_blink(16'h5555);
    push(1'b0, 1'b0, 1'b0, 16'h5555);
    wait_ft(9);

    push(1'b1, 1'b0, 1'b1, 16'h1234);
    push(1'b1, 1'b0, 1'b1, 16'h1234);
    push(1'b1, 1'b0, 1'b1, 16'h1234);
    push(1'b0, 1'b0, 1'b0, 16'h5555);
    pulse_show(16'h1234);
    wait_ft(4);

    push(1'b1, 1'b0, 1'b1, 16'h1234);
    pulse_show(16'h1234);
    wait_ft(1);
    push(1'b1, 1'b0, 1'b1, 16'h9876);
    push(1'b1, 1'b0, 1'b1, 16'h9876);
    push(1'b1, 1'b0, 1'b1, 16'h9876);
    push(1'b0, 1'b0, 1'b0, 16'h5555);
    pulse_show(16'h9876);
    wait_ft(4);

    push(1'b1, 1'b0, 1'b1, 16'h2468);
    pulse_show(16'h2468);
    wait_ft(1);
    lvl = 4'd7;
    push(1'b1, 1'b0, 1'b1, 16'h2468);
    push(1'b1, 1'b0, 1'b1, 16'h2468);
    push_blink(16'h7777);
    push(1'b0, 1'b0, 1'b0, 16'h7777);
    wait_ft(11);

    push(1'b1, 1'b0, 1'b1, 16'h1357);
    push(1'b1, 1'b0, 1'b1, 16'h1357);
    push(1'b1, 1'b0, 1'b1, 16'h1357);
    push(1'b0, 1'b0, 1'b1, 16'h2222);
    push(1'b0, 1'b0, 1'b1, 16'h2222);
    push(1'b0, 1'b1, 1'b1, 16'h2222);
    lvl = 4'd2;
    pulse_show(16'h1357);
    wait_ft(6);

    rst_n = 1'b0;
    #1;
    chk("reset_mid_blink", {24'd0, scan, din, page, blank, frame_tick, busy}, 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
